// File: rtl/cnn_pkg.sv
// Shared constants, types and state encoding for the CNN job feeder.
// Job map: words 0..35 feature map, 36..44 kernel, both row-major.
package cnn_pkg;

  localparam int DW        = 16;
  localparam int FM_WORDS  = 36;
  localparam int K_WORDS   = 9;
  localparam int JOB_WORDS = FM_WORDS + K_WORDS;
  localparam int RES_WORDS = 4;
  localparam int AW        = 6;

  typedef logic [AW-1:0] addr_t;
  typedef logic signed [DW-1:0] word_t;
  typedef logic [1:0] ridx_t;

  localparam addr_t K_BASE    = addr_t'(FM_WORDS);
  localparam addr_t LAST_ADDR = addr_t'(JOB_WORDS - 1);
  localparam ridx_t LAST_RES  = ridx_t'(RES_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_COLLECT,
    ST_FIN
  } feeder_state_e;

  function automatic logic addr_ok(addr_t a);
    return (a < K_BASE) || (a <= LAST_ADDR);
  endfunction

endpackage

// File: rtl/cnn_job_feeder_if.sv
// Engine-side port bundle: job stream out, pooled results back.
// master = feeder (drives in_*/opt), slave = engine (drives out_*).
interface cnn_job_feeder_if;
  import cnn_pkg::*;

  logic  cnn_in_valid;
  word_t cnn_in_data;
  logic  cnn_opt;
  logic  cnn_out_valid;
  word_t cnn_out_data;

  modport master (
    output cnn_in_valid,
    output cnn_in_data,
    output cnn_opt,
    input  cnn_out_valid,
    input  cnn_out_data
  );

  modport slave (
    input  cnn_in_valid,
    input  cnn_in_data,
    input  cnn_opt,
    output cnn_out_valid,
    output cnn_out_data
  );

endinterface

// File: rtl/cnn_job_buffer.sv
// 45-word job register file: one sync write port, one comb read port.
// Ports: clk, we_i/waddr_i/wdata_i write, raddr_i -> rdata_o read.
module cnn_job_buffer
  import cnn_pkg::*;
(
  input  logic  clk,
  input  logic  we_i,
  input  addr_t waddr_i,
  input  word_t wdata_i,
  input  addr_t raddr_i,
  output word_t rdata_o
);

  // Contents survive reset: a job loaded before a reset can be rerun.
  word_t mem_q [JOB_WORDS];

  always_ff @(posedge clk) begin
    if (we_i && addr_ok(waddr_i)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = addr_ok(raddr_i) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/cnn_job_feeder.sv
// Streams one buffered job into the CNN engine and gathers 4 results.
// Ports: clk/rst, cfg_* buffer load, start/start_opt launch,
// busy/done/timeout_err status, res_sel -> res_data readback,
// eng = engine stream interface (master side).
module cnn_job_feeder
  import cnn_pkg::*;
#(
  parameter int TIMEOUT = 128
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  cfg_we,
  input  addr_t cfg_addr,
  input  word_t cfg_wdata,
  input  logic  start,
  input  logic  start_opt,
  output logic  busy,
  output logic  done,
  output logic  timeout_err,
  input  ridx_t res_sel,
  output word_t res_data,
  cnn_job_feeder_if.master eng
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  feeder_state_e st_q, st_d;
  addr_t         beat_q, beat_d;
  logic [TW-1:0] tmr_q, tmr_d;
  ridx_t         idx_q, idx_d;
  logic          tmo_q, tmo_d;
  logic          vld_q, vld_d;
  word_t         dat_q, dat_d;
  logic          opt_q, opt_d;
  word_t         res_q [RES_WORDS];

  logic  buf_we;
  addr_t rd_addr;
  word_t buf_rdata;
  word_t rd_word;
  logic  cap;

  assign buf_we = cfg_we && (st_q == ST_IDLE);

  // Prefetch the word for the next beat one cycle ahead.
  assign rd_addr = (st_q == ST_SEND) ? beat_q + 1'b1 : '0;

  // A write in the start cycle must reach beat 0 of the stream.
  assign rd_word = (buf_we && cfg_addr == rd_addr) ? cfg_wdata
                                                   : buf_rdata;

  assign cap = eng.cnn_out_valid &&
               ((st_q == ST_WAIT) || (st_q == ST_COLLECT));

  cnn_job_buffer u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (rd_addr),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    st_d   = st_q;
    beat_d = beat_q;
    tmr_d  = tmr_q;
    idx_d  = idx_q;
    tmo_d  = tmo_q;
    vld_d  = 1'b0;
    dat_d  = '0;
    opt_d  = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (start) begin
          st_d   = ST_SEND;
          beat_d = '0;
          idx_d  = '0;
          tmo_d  = 1'b0;
          vld_d  = 1'b1;
          dat_d  = rd_word;
          opt_d  = start_opt;
        end
      end
      ST_SEND: begin
        if (beat_q == LAST_ADDR) begin
          st_d  = ST_WAIT;
          tmr_d = '0;
        end else begin
          beat_d = beat_q + 1'b1;
          vld_d  = 1'b1;
          dat_d  = rd_word;
        end
      end
      ST_WAIT, ST_COLLECT: begin
        tmr_d = tmr_q + 1'b1;
        if (cap) begin
          idx_d = idx_q + 1'b1;
          st_d  = ST_COLLECT;
        end
        // Last result beats a coincident timeout.
        if (cap && idx_q == LAST_RES) begin
          st_d = ST_FIN;
        end else if (tmr_q == TMR_LAST) begin
          st_d  = ST_FIN;
          tmo_d = 1'b1;
        end
      end
      ST_FIN: begin
        st_d = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      beat_q <= '0;
      tmr_q  <= '0;
      idx_q  <= '0;
      tmo_q  <= 1'b0;
      vld_q  <= 1'b0;
      dat_q  <= '0;
      opt_q  <= 1'b0;
      for (int i = 0; i < RES_WORDS; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      st_q   <= st_d;
      beat_q <= beat_d;
      tmr_q  <= tmr_d;
      idx_q  <= idx_d;
      tmo_q  <= tmo_d;
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      opt_q  <= opt_d;
      if (cap) begin
        res_q[idx_q] <= eng.cnn_out_data;
      end
    end
  end

  assign busy = (st_q == ST_SEND) ||
                (st_q == ST_WAIT) ||
                (st_q == ST_COLLECT);
  assign done        = (st_q == ST_FIN);
  assign timeout_err = tmo_q;
  assign res_data    = res_q[res_sel];

  assign eng.cnn_in_valid = vld_q;
  assign eng.cnn_in_data  = dat_q;
  assign eng.cnn_opt      = opt_q;

endmodule
